// File: rtl/sseg_pkg.sv
// Shared types, constants and the digit-to-segment encoder for the
// count display path.
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         MAX_DISPLAY = 9999;
  localparam logic [6:0] SEG_BLANK   = 7'b1111111;

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}; non-decimal codes blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, then a single
// DONE cycle that clamps anything above MAX_DISPLAY to 9999 and flags ovf.
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int N = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic [15:0]  bcd,
  output logic         ovf
);

  localparam int BCW = (N > 1) ? $clog2(N) : 1;

  state_t          r_state;
  logic [N-1:0]    r_sh;
  logic [N-1:0]    r_cap;
  logic [16:0]     r_scr;   // four BCD nibbles plus a ten-thousands guard bit
  logic [BCW-1:0]  r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [15:0]     r_bcd;
  logic            r_ovf;

  logic [16:0]     w_adj;
  logic            w_big;

  // Add-3 correction on every nibble that would exceed 9 after the shift.
  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i < 4; i++) begin
      if (r_scr[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
    end
  end

  assign w_big = 32'(r_cap) > 32'(MAX_DISPLAY);

  // Conversion FSM: capture, N shift steps, then clamp and publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cap   <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sh    <= bin;
            r_cap   <= bin;
            r_scr   <= '0;
            r_cnt   <= BCW'(N - 1);
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_scr <= {w_adj[15:0], r_sh[N-1]};
          r_sh  <= r_sh << 1;
          r_cnt <= r_cnt - BCW'(1);
          if (r_cnt == '0) r_state <= DONE;
        end
        DONE: begin
          if (w_big) begin
            r_bcd <= 16'h9999;
            r_ovf <= 1'b1;
          end else begin
            r_bcd <= r_scr[15:0];
            r_ovf <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;

endmodule

// File: rtl/count_display_driver.sv
// Drives a 4-digit common-anode multiplexed 7-segment display from a binary
// count. Conversion runs in the background; the scan only ever reads the
// committed digit registers, so the display never shows a partial result.
module count_display_driver
  import sseg_pkg::*;
#(
  parameter int N           = 14,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] bin,
  output logic [3:0]   an,
  output logic [6:0]   seg,
  output logic         dp,
  output logic         busy,
  output logic         ovf
);

  localparam int SCW = $clog2(REFRESH_DIV);

  logic [N-1:0]    r_last_bin;
  logic            r_pending;
  logic [3:0][3:0] r_dig;
  logic            r_ovf;
  logic [SCW-1:0]  r_scan;
  logic [1:0]      r_idx;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;

  logic            w_start;
  logic            w_busy;
  logic            w_done;
  logic            w_ovf;
  logic [15:0]     w_bcd;
  logic [1:0]      w_idx_nxt;
  logic [3:0]      w_lz;
  logic            w_blank;
  logic [6:0]      w_seg_nxt;
  logic            w_wrap;

  // Converter is idle exactly when busy is low; only the latest value is taken.
  assign w_start = !w_busy && ((bin != r_last_bin) || r_pending);

  bin2bcd_seq #(.N(N)) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .bin   (bin),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd),
    .ovf   (w_ovf)
  );

  // Change detect; pending forces one conversion after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_bin <= '0;
      r_pending  <= 1'b1;
    end else if (w_start) begin
      r_last_bin <= bin;
      r_pending  <= 1'b0;
    end
  end

  // Commit converted digits and overflow flag on the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dig <= '0;
      r_ovf <= 1'b0;
    end else if (w_done) begin
      r_dig <= w_bcd;
      r_ovf <= w_ovf;
    end
  end

  // Leading-zero mask: digit i blanks if it and all higher digits are zero.
  always_comb begin
    w_idx_nxt = r_idx + 2'd1;
    w_lz[3]   = ~|r_dig[3];
    w_lz[2]   = ~|r_dig[3:2];
    w_lz[1]   = ~|r_dig[3:1];
    w_lz[0]   = 1'b0;
    w_blank   = (BLANK_LZ != 0) && w_lz[w_idx_nxt];
    w_seg_nxt = w_blank ? SEG_BLANK : seg_encode(r_dig[w_idx_nxt]);
    w_wrap    = (r_scan == SCW'(REFRESH_DIV - 1));
  end

  // Refresh prescaler and digit scan; an/seg move together on each wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan <= '0;
      r_idx  <= 2'd0;
      r_an   <= 4'b1110;
      r_seg  <= 7'b1000000;
    end else if (w_wrap) begin
      r_scan <= '0;
      r_idx  <= w_idx_nxt;
      r_an   <= ~(4'b0001 << w_idx_nxt);
      r_seg  <= w_seg_nxt;
    end else begin
      r_scan <= r_scan + SCW'(1);
    end
  end

  // Decimal point is unused and held off.
  always_ff @(posedge clk) begin
    r_dp <= 1'b1;
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = r_dp;
  assign busy = w_busy;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench: stimulus queues expected values, a monitor pairs each
// completed conversion with the next four digit slots of the scan.
module tb_count_display_driver;
  localparam int N  = 14;
  localparam int RD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rst_q = 1'b1;
  logic [N-1:0] bin = '0;
  logic [3:0]   an, an_nb;
  logic [6:0]   seg, seg_nb;
  logic         dp, dp_nb, busy, busy_nb, ovf, ovf_nb;

  count_display_driver #(.N(N), .REFRESH_DIV(RD), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .bin(bin), .an(an), .seg(seg),
    .dp(dp), .busy(busy), .ovf(ovf));

  count_display_driver #(.N(N), .REFRESH_DIV(RD), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .bin(bin), .an(an_nb), .seg(seg_nb),
    .dp(dp_nb), .busy(busy_nb), .ovf(ovf_nb));

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int wfrom_q[$];
  int wval_q[$];

  logic [6:0] segt [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Reference: clamp, take decimal digit i, blank when value < 10^i.
  function automatic logic [6:0] exp_seg(input int val, input int i, input bit blz);
    int v;
    int p;
    v = (val > 9999) ? 9999 : val;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (blz && i > 0 && v < p) return 7'b1111111;
    return segt[(v / p) % 10];
  endfunction

  // Monitor
  int cyc = 0, gap = 0, run = 0, idx = 0, rem = 4;
  logic pbusy = 1'b0;
  logic [3:0] pan = 4'b1110;

  always @(negedge clk) begin
    logic [3:0] ea;
    int v;
    cyc++;
    if (rst_q) begin
      gap = 0; run = 0; idx = 0; rem = 4; pbusy = 1'b0; pan = an;
      wfrom_q.delete(); wval_q.delete();
    end else begin
      gap++;
      if (busy) run++;
      if (pbusy && !busy) begin
        chk("busy_len", run, N + 1);
        run = 0;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_conv: got a conversion, expected none queued");
        end else begin
          wfrom_q.push_back(cyc + 2);
          wval_q.push_back(exp_q.pop_front());
        end
      end
      if (an != pan) begin
        idx = (idx + 1) % 4;
        ea = 4'b1111; ea[idx] = 1'b0;
        chk("scan_period", gap, RD);
        chk("an", an, ea);
        chk("an_nb", an_nb, ea);
        gap = 0;
        if (wfrom_q.size() > 0 && cyc >= wfrom_q[0]) begin
          v = wval_q[0];
          if (rem == 4) begin
            chk($sformatf("ovf val=%0d", v), ovf, (v > 9999) ? 1 : 0);
            chk($sformatf("ovf_nb val=%0d", v), ovf_nb, (v > 9999) ? 1 : 0);
          end
          chk($sformatf("seg[%0d] val=%0d", idx, v), seg, exp_seg(v, idx, 1'b1));
          chk($sformatf("seg_nb[%0d] val=%0d", idx, v), seg_nb, exp_seg(v, idx, 1'b0));
          rem--;
          if (rem == 0) begin
            rem = 4;
            void'(wfrom_q.pop_front());
            void'(wval_q.pop_front());
          end
        end
      end
      pbusy = busy;
      pan = an;
    end
  end

  task automatic wait_lvl(input logic lvl, input int lim, input string nm);
    int n = 0;
    while (busy !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (busy !== lvl) begin
      tests++; fails++;
      $display("FAIL %s: busy=%b after %0d cycles, expected %b", nm, busy, lim, lvl);
    end
  endtask

  task automatic conv(input int v);
    @(negedge clk);
    bin = N'(v);
    exp_q.push_back(v);
    wait_lvl(1'b1, 5, "conv_start");
    wait_lvl(1'b0, 30, "conv_end");
    repeat (20) @(negedge clk);
  endtask

  // Stimulus
  initial begin
    int dir [7] = '{1234, 12000, 42, 5, 9999, 10000, 16383};
    int prev;
    int r;

    rst = 1'b1;
    bin = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'b1000000);
    chk("rst_seg_nb", seg_nb, 7'b1000000);
    chk("rst_dp", dp, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    exp_q.push_back(0);
    rst = 1'b0;
    @(negedge clk);
    chk("pending_start", busy, 1);
    wait_lvl(1'b0, 30, "first_end");
    repeat (20) @(negedge clk);

    foreach (dir[i]) conv(dir[i]);

    // Change while busy: 101 must wait for the 100 conversion to finish.
    @(negedge clk);
    bin = N'(100);
    exp_q.push_back(100);
    wait_lvl(1'b1, 5, "c100_start");
    repeat (5) @(negedge clk);
    bin = N'(101);
    exp_q.push_back(101);
    wait_lvl(1'b0, 30, "c100_end");
    @(negedge clk);
    chk("restart_after_busy", busy, 1);
    wait_lvl(1'b0, 30, "c101_end");
    repeat (20) @(negedge clk);

    prev = 101;
    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(0, 16383);
      if (r == prev || r == 777) r = (r + 1) % 16384;
      if (r == prev || r == 777) r = (r + 1) % 16384;
      conv(r);
      prev = r;
    end

    // Reset in the middle of a conversion.
    @(negedge clk);
    bin = N'(777);
    wait_lvl(1'b1, 5, "c777_start");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_an", an, 4'b1110);
    chk("midrst_seg", seg, 7'b1000000);
    chk("midrst_ovf", ovf, 0);
    rst = 1'b0;
    exp_q.push_back(777);
    @(negedge clk);
    chk("midrst_restart", busy, 1);
    wait_lvl(1'b0, 30, "c777_end");
    repeat (30) @(negedge clk);

    chk("scoreboard_drained", exp_q.size() + wval_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
